// File: rtl/blue_sequencer_pkg.sv
// blue_sequencer_pkg: shared states, opcode classes and flag bit positions
package blue_sequencer_pkg;
  localparam int DEF_AW = 12;
  localparam int DEF_DW = 16;
  localparam int Z_BIT = 2;
  localparam int N_BIT = 1;
  localparam int C_BIT = 0;
  localparam logic [3:0] OP_HLT  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_EXCH = 4'd8;
  localparam logic [3:0] OP_LDA  = 4'd9;
  localparam logic [3:0] OP_JMP  = 4'd10;
  localparam logic [3:0] OP_JZ   = 4'd11;
  localparam logic [3:0] OP_JC   = 4'd12;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_LOAD, S_WB, S_HALT} state_t;
  typedef enum logic [2:0] {K_HLT, K_ALU, K_LDA, K_JMP, K_NOP} kind_t;
endpackage

// File: rtl/blue_decode.sv
// blue_decode: instruction class and branch-taken from opcode and flags
module blue_decode
  import blue_sequencer_pkg::*;
(
  input  logic [3:0] opc,
  input  logic       z,
  input  logic       c,
  output kind_t      kind,
  output logic       taken
);
  always_comb begin
    kind = opc == OP_HLT ? K_HLT :
           opc >= OP_ADD && opc <= OP_EXCH ? K_ALU :
           opc == OP_LDA ? K_LDA :
           opc <= OP_JC ? K_JMP : K_NOP;
    taken = opc == OP_JMP || (opc == OP_JZ && z) || (opc == OP_JC && c);
  end
endmodule

// File: rtl/blue_sequencer.sv
// blue_sequencer: fetch/decode/execute control for the blue ALU datapath
module blue_sequencer
  import blue_sequencer_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] op_code,
  output logic [DW-1:0] a_reg,
  output logic [DW-1:0] b_reg,
  input  logic [DW-1:0] a_next,
  input  logic [DW-1:0] b_next,
  input  logic [2:0]    znc_next,
  output logic [2:0]    znc,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted
);
  state_t st;
  kind_t kind;
  logic taken;
  logic [AW-1:0] tgt;
  assign tgt = op_code[AW-1:0];
  blue_decode u_dec (
    .opc  (op_code[DW-1 -: 4]),
    .z    (znc[Z_BIT]),
    .c    (znc[C_BIT]),
    .kind (kind),
    .taken(taken)
  );
  // mem_addr is registered alongside pc so it tracks pc outside FETCH/LOAD
  always_ff @(posedge clk)
    if (!rst_n) begin
      st <= S_IDLE;
      mem_req <= 1'b0;
      mem_addr <= '0;
      op_code <= '0;
      a_reg <= '0;
      b_reg <= '0;
      znc <= '0;
      pc <= '0;
      busy <= 1'b0;
      halted <= 1'b0;
    end else begin
      unique case (st)
        S_IDLE, S_HALT: if (run) begin
          st <= S_FETCH;
          mem_req <= 1'b1;
          busy <= 1'b1;
          halted <= 1'b0;
          if (st == S_IDLE) begin
            pc <= '0;
            mem_addr <= '0;
          end
        end
        S_FETCH: if (mem_ack) begin
          op_code <= mem_rdata;
          pc <= pc + AW'(1);
          mem_addr <= pc + AW'(1);
          mem_req <= 1'b0;
          st <= S_DECODE;
        end
        S_DECODE: begin
          st <= kind == K_HLT ? S_HALT : kind == K_ALU ? S_EXEC : kind == K_LDA ? S_LOAD : S_FETCH;
          mem_req <= kind != K_HLT && kind != K_ALU;
          busy <= kind != K_HLT;
          halted <= kind == K_HLT;
          if (kind == K_LDA) mem_addr <= tgt;
          if (taken) begin
            pc <= tgt;
            mem_addr <= tgt;
          end
        end
        S_EXEC: st <= S_WB;
        S_WB: begin
          a_reg <= a_next;
          b_reg <= b_next;
          znc <= znc_next;
          mem_req <= 1'b1;
          st <= S_FETCH;
        end
        S_LOAD: if (mem_ack) begin
          a_reg <= mem_rdata;
          znc[Z_BIT] <= mem_rdata == '0;
          znc[N_BIT] <= mem_rdata[DW-1];
          mem_addr <= pc;
          st <= S_FETCH;
        end
      endcase
    end
endmodule

// File: tb/tb_blue_sequencer.sv
// tb_blue_sequencer: instruction-level reference model with random memory waits and programs
module tb_blue_sequencer;
  localparam int AW = 12;
  localparam int DW = 16;
  logic clk = 1'b0, rst_n = 1'b0, run = 1'b0, mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic mem_req, busy, halted;
  logic [AW-1:0] mem_addr, pc;
  logic [DW-1:0] op_code, a_reg, b_reg, a_next, b_next;
  logic [2:0] znc, znc_next;
  logic [DW-1:0] mem [4096];
  int checks = 0, failures = 0, cyc = 0, exp_cyc = 0, wcnt = 0, wmax = 0, force_w = -1, run_prob = 0;
  bit req_open, exp_load, halt_pend, m_stop = 1'b1, m_halt, run_now;
  logic [AW-1:0] m_pc, ld_tgt;
  logic [DW-1:0] m_a, m_b, exp_op;
  logic [2:0] m_f;

  always #5 clk = ~clk;

  blue_sequencer #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .op_code(op_code), .a_reg(a_reg),
    .b_reg(b_reg), .a_next(a_next), .b_next(b_next), .znc_next(znc_next), .znc(znc),
    .pc(pc), .busy(busy), .halted(halted)
  );

  // external datapath: returns {A_out, B_out, ZNC_out}
  function automatic logic [34:0] alu(input logic [15:0] op, input logic [15:0] a, input logic [15:0] b, input logic [2:0] f);
    logic [16:0] r;
    logic [15:0] na, nb;
    logic c;
    na = a; nb = b; c = f[0];
    case (op[15:12])
      4'd1: begin r = {1'b0, a} + {1'b0, b}; na = r[15:0]; c = r[16]; end
      4'd2: begin r = {1'b0, a} - {1'b0, b}; na = r[15:0]; c = r[16]; end
      4'd3: na = a | b;
      4'd4: na = a & b;
      4'd5: na = a ^ b;
      4'd6: begin na = {1'b0, a[15:1]}; c = a[0]; end
      4'd7: na = b;
      4'd8: begin na = b; nb = a; end
      default: ;
    endcase
    return {na, nb, na == 16'd0, na[15], c};
  endfunction

  assign {a_next, b_next, znc_next} = alu(op_code, a_reg, b_reg, znc);

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_pc = '0; m_a = '0; m_b = '0; m_f = '0; exp_op = '0;
    m_stop = 1'b1; m_halt = 1'b0; halt_pend = 1'b0; exp_load = 1'b0; req_open = 1'b0;
  endtask

  // whole-instruction semantics plus the cycle at which the next fetch must be acked
  task automatic execute(input logic [15:0] w);
    logic [3:0] o;
    logic [11:0] t;
    logic [15:0] v;
    o = w[15:12]; t = w[11:0];
    m_pc = m_pc + 12'd1;
    exp_cyc = cyc + 2;
    if (o == 4'd0) halt_pend = 1'b1;
    else if (o <= 4'd8) begin
      {m_a, m_b, m_f} = alu(w, m_a, m_b, m_f);
      exp_cyc = cyc + 4;
    end else if (o == 4'd9) begin
      v = mem[t];
      m_a = v;
      m_f = {v == 16'd0, v[15], m_f[0]};
      exp_load = 1'b1; ld_tgt = t;
      exp_cyc = cyc + 3;
    end else if (o == 4'd10 || (o == 4'd11 && m_f[2]) || (o == 4'd12 && m_f[0])) m_pc = t;
  endtask

  task automatic step();
    logic p_req;
    logic [11:0] p_addr;
    logic [15:0] p_op, p_a, p_b;
    logic [2:0] p_f;
    bit ack, was_stop, was_halt;
    p_req = mem_req; p_addr = mem_addr; p_op = op_code; p_a = a_reg; p_b = b_reg; p_f = znc;
    if (mem_req === 1'b1) begin
      if (!req_open) begin
        req_open = 1'b1;
        wcnt = force_w >= 0 ? force_w : int'($urandom_range(0, wmax));
        exp_cyc += wcnt;
      end
      mem_ack = wcnt == 0;
      mem_rdata = mem_ack ? mem[mem_addr] : 16'($urandom);
      if (wcnt > 0) wcnt--;
    end else begin
      mem_ack = $urandom_range(0, 5) == 0;
      mem_rdata = 16'($urandom);
    end
    run = run_now || (run_prob > 0 && $urandom_range(0, 99) < run_prob);
    @(posedge clk);
    cyc++;
    ack = p_req === 1'b1 && mem_ack && rst_n;
    if (!rst_n) model_reset();
    else begin
      was_stop = m_stop; was_halt = m_halt;
      if (halt_pend) begin m_stop = 1'b1; m_halt = 1'b1; halt_pend = 1'b0; end
      if (run && was_stop) begin
        m_stop = 1'b0; m_halt = 1'b0; exp_cyc = cyc + 1;
        if (!was_halt) m_pc = '0;
      end
      if (ack) begin
        req_open = 1'b0;
        if (exp_load) begin
          chk("load_addr", p_addr, ld_tgt);
          exp_load = 1'b0;
        end else begin
          chk("fetch_addr", p_addr, m_pc);
          chk("fetch_cycle", cyc, exp_cyc);
          chk("a_reg", p_a, m_a);
          chk("b_reg", p_b, m_b);
          chk("znc", p_f, m_f);
          exp_op = mem_rdata;
          execute(mem_rdata);
        end
      end
    end
    #1;
    if (!rst_n) chk("reset_outputs", {mem_req, mem_addr, op_code, a_reg, b_reg, znc, pc, busy, halted}, 80'd0);
    else begin
      chk("busy", busy, !m_stop);
      chk("halted", halted, m_stop && m_halt);
      chk("op_code", op_code, exp_op);
      if (!mem_req) chk("addr_is_pc", mem_addr, pc);
      if (m_stop) chk("req_when_stopped", mem_req, 1'b0);
      if (p_req === 1'b1 && !ack) begin
        chk("req_hold", mem_req, 1'b1);
        chk("addr_hold", mem_addr, p_addr);
      end
    end
  endtask

  task automatic go(input int exp_lat);
    int t0;
    run_now = 1'b1;
    step();
    run_now = 1'b0;
    t0 = cyc;
    for (int i = 0; i < 400 && halted !== 1'b1; i++) step();
    chk("halt_reached", halted, 1'b1);
    if (exp_lat >= 0) chk("halt_latency", cyc - t0, exp_lat);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    mem[12'h000] = 16'h9005; mem[12'h001] = 16'h0000; mem[12'h002] = 16'hB00A;
    mem[12'h005] = 16'h0000; mem[12'h006] = 16'h8001;
    mem[12'h00A] = 16'h9006; mem[12'h00B] = 16'h0000; mem[12'h00C] = 16'hB00A;
    mem[12'h00D] = 16'hAFFE; mem[12'hFFE] = 16'hD000; mem[12'hFFF] = 16'hA011;
    mem[12'h011] = 16'h0000;
    mem[12'h012] = 16'h9020; mem[12'h013] = 16'h8000; mem[12'h014] = 16'h9021;
    mem[12'h015] = 16'h8000; mem[12'h016] = 16'h1000; mem[12'h017] = 16'h0000;
    mem[12'h018] = 16'h9030;
    mem[12'h020] = 16'hABCD; mem[12'h021] = 16'h1234; mem[12'h030] = 16'h5555;
    model_reset();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
    // LDA of zero then HLT, zero-wait memory
    go(5);
    chk("lda0_a", a_reg, 16'h0000);
    chk("lda0_znc", znc, 3'b100);
    chk("lda0_pc", pc, 12'h002);
    // taken JZ, then LDA of a negative word, every request waiting 3 cycles
    force_w = 3;
    go(19);
    force_w = -1;
    chk("lda_neg_a", a_reg, 16'h8001);
    chk("lda_neg_znc", znc, 3'b010);
    chk("jz_taken_pc", pc, 12'h00C);
    // JZ not taken, jump to top of memory and wrap back
    wmax = 3;
    go(-1);
    chk("wrap_pc", pc, 12'h012);
    // EXCH swap followed by ADD
    go(-1);
    chk("exch_add_a", a_reg, 16'hBE01);
    chk("exch_add_b", b_reg, 16'h1234);
    chk("exch_add_znc", znc, 3'b010);
    chk("exch_add_pc", pc, 12'h018);
    // reset while a LOAD is waiting for memory
    force_w = 12;
    run_now = 1'b1;
    step();
    run_now = 1'b0;
    for (int i = 0; i < 60 && !(exp_load && mem_req === 1'b1); i++) step();
    repeat (3) step();
    chk("load_wait_req", mem_req, 1'b1);
    chk("load_wait_addr", mem_addr, 12'h030);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    force_w = -1;
    repeat (6) step();
    go(-1);
    chk("restart_pc", pc, 12'h002);
    chk("restart_a", a_reg, 16'h0000);
    // random programs, random waits, stray acks and run pulses
    for (int i = 0; i < 4096; i++) begin
      int r;
      logic [3:0] o;
      r = $urandom_range(0, 99);
      o = r < 4 ? 4'd0 : r < 60 ? 4'($urandom_range(1, 8)) : r < 72 ? 4'd9 :
          r < 80 ? 4'd10 : r < 90 ? 4'($urandom_range(11, 12)) : 4'($urandom_range(13, 15));
      mem[i] = {o, 12'($urandom)};
    end
    run_prob = 3;
    repeat (8000) step();
    run_prob = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/blue_sequencer.md
BLUE_SEQUENCER -- requirements
Module: blue_sequencer

Interface
REQ-001 SHALL define parameter AW, default 12, meaning program/memory address width.
REQ-002 SHALL define parameter DW, default 16, meaning data/instruction width.
REQ-003 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- run  in  1  start pulse, sampled in IDLE/HALT.
- mem_req  out  1  memory read request.
- mem_addr  out  AW  memory read address.
- mem_ack  in  1  read data valid.
- mem_rdata  in  DW  read data.
- op_code  out  DW  instruction register, drives the ALU datapath opCode.
- a_reg, b_reg  out  DW  A/B registers, drive the datapath A_in/B_in.
- a_next, b_next  in  DW  datapath A_out/B_out.
- znc_next  in  3  datapath ZNC_out.
- znc  out  3  flag register {Z,N,C}, also feeds datapath ZNC_in.
- pc  out  AW  program counter.
- busy  out  1  high in any state other than IDLE/HALT.
- halted  out  1  high in HALT.

Function
REQ-004 SHALL implement the states IDLE, FETCH, DECODE, EXEC, LOAD, WB and HALT.
REQ-005 SHALL decode the class from op_code[15:12]:
- 0 = HLT
- 1..8 = ALU (ADD, SUB, OR, AND, XOR, SHR, MOV, EXCH)
- 9 = LDA (A <= mem[op_code[AW-1:0]])
- 10 = JMP
- 11 = JZ (jump if Z)
- 12 = JC (jump if C)
- 13..15 = NOP
REQ-006 IDLE: on run=1, SHALL set pc=0 and go to FETCH next cycle.
REQ-007 FETCH: SHALL assert mem_req=1 with mem_addr=pc, both held stable until mem_ack=1 is sampled. On that edge it SHALL load op_code=mem_rdata, set pc=pc+1 (wrapping modulo 2^AW), deassert mem_req and go to DECODE.
REQ-008 SHALL ignore mem_ack while mem_req=0.
REQ-009 DECODE transitions:
- HLT -> HALT.
- ALU -> EXEC.
- LDA -> LOAD.
- JMP -> FETCH, with pc=op_code[AW-1:0].
- JZ/JC -> FETCH, with pc=target if the tested znc bit is 1, else pc unchanged.
- NOP -> FETCH.
REQ-010 EXEC: a single settle cycle with a_reg, b_reg, znc and op_code stable, then WB.
REQ-011 WB: SHALL capture a_reg=a_next, b_reg=b_next and znc=znc_next in one edge, then go to FETCH. EXCH SHALL therefore swap A and B atomically.
REQ-012 LOAD: SHALL assert mem_req with mem_addr=op_code[AW-1:0] until mem_ack. On ack it SHALL set a_reg=mem_rdata, znc={a==0, a[DW-1], znc[0]} (C preserved), then go to FETCH.
REQ-013 HALT: SHALL hold all registers. run=1 SHALL resume at FETCH with pc unchanged (the instruction after HLT).
REQ-014 Latency with zero-wait memory (mem_ack in the first request cycle):
- ALU: 4 cycles (FETCH, DECODE, EXEC, WB).
- LDA: 3 cycles.
- JMP/Jcc/NOP: 2 cycles.
REQ-015 Outside FETCH/LOAD, mem_req SHALL be 0 and mem_addr SHALL equal pc.
REQ-016 Register update rule: a_reg, b_reg and znc SHALL change only in WB or on a LOAD ack; op_code only on a FETCH ack; pc only in IDLE, FETCH or DECODE.
REQ-017 run=1 in any state other than IDLE/HALT SHALL be ignored.

Reset
REQ-018 While rst_n=0 at a rising clk edge, SHALL enter IDLE and clear every output: mem_req=0, mem_addr=0, op_code=0, a_reg=0, b_reg=0, znc=0, pc=0, busy=0, halted=0.
REQ-019 Reset mid-transaction (mem_req high) SHALL drop mem_req the cycle after the reset edge. Any later mem_ack SHALL be ignored.

Structure
REQ-020 SHALL place in a shared package: the state enum, the 4-bit class codes, the ZNC bit indices (Z=2, N=1, C=0) and the default AW/DW.
REQ-021 SHALL contain one sub-module, blue_decode: combinational op_code[15:12] -> class and jump-taken, from the znc bits.
REQ-022 SHALL NOT instantiate the ALU datapath; it is connected alongside at the top level.

Verification
REQ-023 Reset, then run pulse, memory {0:0x1000 ADD, 1:0x0000 HLT}, a/b initialised via LDA preamble -> ADD result in a_reg after WB; halted=1; pc=2.
REQ-024 Memory ack delayed 3 cycles on FETCH -> mem_req and mem_addr stable for all 3 wait cycles; op_code loads only on the ack edge; ack pulses with mem_req=0 produce no change.
REQ-025 LDA 0x9005 with mem[5]=0x0000 -> a_reg=0, znc=3'b100 (C preserved); LDA with mem[5]=0x8001 -> a_reg=0x8001, N=1, Z=0.
REQ-026 JZ 0xB00A with Z=1 -> next fetch at address 0x00A. With Z=0 -> next fetch at pc+1. JMP at address 0xFFF with target 0 -> pc wraps correctly.
REQ-027 EXCH with A=0x1234, B=0xABCD -> after WB, A=0xABCD and B=0x1234 in the same cycle.
REQ-028 rst_n=0 asserted during LOAD wait -> next cycle state IDLE with all outputs 0; a following run pulse restarts from pc=0.
